// File: rtl/mccu_pkg.sv
// Shared encodings for the multicycle control unit: states, instruction fields,
// ALU codes, mux selects and the decoded instruction class.
package mccu_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_SRA = 6'b000011;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   localparam logic [1:0] ASB_QB   = 2'b00;
   localparam logic [1:0] ASB_FOUR = 2'b01;
   localparam logic [1:0] ASB_IMM  = 2'b10;

   localparam logic [1:0] PC_P4  = 2'b00;
   localparam logic [1:0] PC_BPC = 2'b01;
   localparam logic [1:0] PC_QA  = 2'b10;
   localparam logic [1:0] PC_JPC = 2'b11;

   typedef enum logic [3:0] {
      C_ILL, C_RALU, C_SHIFT, C_JR, C_BEQ, C_BNE,
      C_IALU, C_LW, C_SW, C_J, C_JAL
   } iclass_e;

   typedef struct packed {
      iclass_e    cls;
      logic [3:0] aluc;
      logic       sext;
   } dec_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational op/func decode into an instruction class plus the ALU code
// and sign-extension select used in EXE.
module mccu_decode
   import mccu_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] func_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o.cls  = C_ILL;
      dec_o.aluc = ALUC_ADD;
      dec_o.sext = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            case (func_i)
               F_ADD:   dec_o.cls = C_RALU;
               F_SUB:   begin dec_o.cls = C_RALU;  dec_o.aluc = ALUC_SUB; end
               F_AND:   begin dec_o.cls = C_RALU;  dec_o.aluc = ALUC_AND; end
               F_OR:    begin dec_o.cls = C_RALU;  dec_o.aluc = ALUC_OR;  end
               F_XOR:   begin dec_o.cls = C_RALU;  dec_o.aluc = ALUC_XOR; end
               F_SLL:   begin dec_o.cls = C_SHIFT; dec_o.aluc = ALUC_SLL; end
               F_SRL:   begin dec_o.cls = C_SHIFT; dec_o.aluc = ALUC_SRL; end
               F_SRA:   begin dec_o.cls = C_SHIFT; dec_o.aluc = ALUC_SRA; end
               F_JR:    dec_o.cls = C_JR;
               default: dec_o.cls = C_ILL;
            endcase
         end
         OP_ADDI: begin dec_o.cls = C_IALU; dec_o.sext = 1'b1; end
         OP_ANDI: begin dec_o.cls = C_IALU; dec_o.aluc = ALUC_AND; end
         OP_ORI:  begin dec_o.cls = C_IALU; dec_o.aluc = ALUC_OR;  end
         OP_XORI: begin dec_o.cls = C_IALU; dec_o.aluc = ALUC_XOR; end
         OP_LUI:  begin dec_o.cls = C_IALU; dec_o.aluc = ALUC_LUI; end
         OP_LW:   begin dec_o.cls = C_LW;   dec_o.sext = 1'b1; end
         OP_SW:   begin dec_o.cls = C_SW;   dec_o.sext = 1'b1; end
         OP_BEQ:  begin dec_o.cls = C_BEQ;  dec_o.aluc = ALUC_SUB; end
         OP_BNE:  begin dec_o.cls = C_BNE;  dec_o.aluc = ALUC_SUB; end
         OP_J:    dec_o.cls = C_J;
         OP_JAL:  dec_o.cls = C_JAL;
         default: dec_o.cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/mccu_fsm.sv
// Multicycle control unit: IF/ID/EXE/MEM/WB sequencer with memory-ready
// handshake and a saturating memory-stall counter.
module mccu_fsm
   import mccu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             z,
   input  logic             mem_rdy,
   output logic             rmem,
   output logic             wmem,
   output logic             iord,
   output logic             wpc,
   output logic             wir,
   output logic             wreg,
   output logic             regrt,
   output logic             m2reg,
   output logic             shift,
   output logic             jal,
   output logic             sext,
   output logic             selpc,
   output logic [1:0]       alusrcb,
   output logic [3:0]       aluc,
   output logic [1:0]       pcsrc,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   dec_t             dec;
   logic             wpc_c, wir_c, wreg_c, rmem_c, wmem_c, ill_c;

   mccu_decode u_decode (
      .op_i   (op),
      .func_i (func),
      .dec_o  (dec)
   );

   always_ff @(posedge clk) begin
      if (clrn) begin
         state_q <= S_IF;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IF || state_q == S_MEM) && !mem_rdy && stall_q != '1)
         stall_d = stall_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      wpc_c   = 1'b0;
      wir_c   = 1'b0;
      wreg_c  = 1'b0;
      rmem_c  = 1'b0;
      wmem_c  = 1'b0;
      ill_c   = 1'b0;
      iord    = 1'b0;
      regrt   = 1'b0;
      m2reg   = 1'b0;
      shift   = 1'b0;
      jal     = 1'b0;
      sext    = 1'b0;
      selpc   = 1'b0;
      alusrcb = ASB_QB;
      aluc    = ALUC_ADD;
      pcsrc   = PC_P4;
      case (state_q)
         S_IF: begin
            rmem_c  = 1'b1;
            selpc   = 1'b1;
            alusrcb = ASB_FOUR;
            if (mem_rdy) begin
               wir_c   = 1'b1;
               wpc_c   = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            case (dec.cls)
               C_J: begin
                  wpc_c   = 1'b1;
                  pcsrc   = PC_JPC;
                  state_d = S_IF;
               end
               C_JAL: begin
                  wpc_c   = 1'b1;
                  pcsrc   = PC_JPC;
                  wreg_c  = 1'b1;
                  jal     = 1'b1;
                  state_d = S_IF;
               end
               C_ILL: begin
                  ill_c   = 1'b1;
                  state_d = S_IF;
               end
               default: state_d = S_EXE;
            endcase
         end
         S_EXE: begin
            aluc    = dec.aluc;
            sext    = dec.sext;
            state_d = S_WB;
            case (dec.cls)
               C_SHIFT: shift = 1'b1;
               C_JR: begin
                  wpc_c   = 1'b1;
                  pcsrc   = PC_QA;
                  state_d = S_IF;
               end
               C_BEQ, C_BNE: begin
                  if ((dec.cls == C_BEQ && z) || (dec.cls == C_BNE && !z)) begin
                     wpc_c = 1'b1;
                     pcsrc = PC_BPC;
                  end
                  state_d = S_IF;
               end
               C_IALU: alusrcb = ASB_IMM;
               C_LW, C_SW: begin
                  alusrcb = ASB_IMM;
                  state_d = S_MEM;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            // Selects stay frozen while waiting so the memory sees a stable request.
            iord = 1'b1;
            if (dec.cls == C_LW) rmem_c = 1'b1;
            else                 wmem_c = 1'b1;
            if (mem_rdy) state_d = (dec.cls == C_LW) ? S_WB : S_IF;
         end
         S_WB: begin
            wreg_c  = 1'b1;
            regrt   = (dec.cls == C_IALU) || (dec.cls == C_LW);
            m2reg   = (dec.cls == C_LW);
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // Side-effecting strobes are held off for the whole reset cycle.
   assign wpc     = wpc_c  & ~clrn;
   assign wir     = wir_c  & ~clrn;
   assign wreg    = wreg_c & ~clrn;
   assign rmem    = rmem_c & ~clrn;
   assign wmem    = wmem_c & ~clrn;
   assign illegal = ill_c  & ~clrn;

   assign state     = state_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mccu_fsm.sv
// Scoreboard bench for mccu_fsm: each cycle queues its expected control word,
// the observed word is queued at the falling edge and the two are compared per task.
module tb_mccu_fsm;
   import mccu_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          clrn = 1'b1;
   logic [5:0]    op = '0, func = '0;
   logic          z = 1'b0, mem_rdy = 1'b0;
   logic          rmem, wmem, iord, wpc, wir, wreg, regrt, m2reg, shift, jal, sext, selpc;
   logic [1:0]    alusrcb, pcsrc;
   logic [3:0]    aluc;
   logic [2:0]    state;
   logic          illegal;
   logic [CW-1:0] stall_cnt;

   mccu_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
      .rmem(rmem), .wmem(wmem), .iord(iord), .wpc(wpc), .wir(wir), .wreg(wreg),
      .regrt(regrt), .m2reg(m2reg), .shift(shift), .jal(jal), .sext(sext),
      .selpc(selpc), .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc),
      .state(state), .illegal(illegal), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    st;
      logic          wpc, wir, wreg, rmem, wmem, iord, ill, m2reg, regrt, jal, shift, sext, selpc;
      logic [1:0]    pcsrc, alusrcb;
      logic [3:0]    aluc;
      logic [CW-1:0] stall;
   } obs_t;

   obs_t          exp_q[$];
   obs_t          obs_q[$];
   string         nm_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] sc = '0;

   function automatic obs_t rec(input logic [2:0] s);
      obs_t r;
      r = '0;
      r.st = s;
      r.stall = sc;
      r.iord = (s == S_MEM);
      return r;
   endfunction

   function automatic obs_t fetch(input logic mr);
      obs_t r;
      r = rec(S_IF);
      r.rmem = 1'b1; r.selpc = 1'b1; r.alusrcb = ASB_FOUR; r.aluc = ALUC_ADD;
      r.wir = mr; r.wpc = mr;
      return r;
   endfunction

   function automatic obs_t rst_rec();
      obs_t r;
      r = fetch(1'b0);
      r.rmem = 1'b0;
      r.stall = '0;
      return r;
   endfunction

   // Selects are only meaningful where they steer something; mask the rest.
   function automatic obs_t sample();
      obs_t o;
      logic act;
      act = (state == S_IF) || (state == S_EXE);
      o.st = state; o.wpc = wpc; o.wir = wir; o.wreg = wreg; o.rmem = rmem;
      o.wmem = wmem; o.iord = iord; o.ill = illegal;
      o.m2reg = wreg & m2reg; o.regrt = wreg & regrt; o.jal = wreg & jal;
      o.shift = (state == S_EXE) & shift; o.sext = (state == S_EXE) & sext;
      o.selpc = act & selpc;
      o.alusrcb = act ? alusrcb : 2'b00;
      o.aluc = act ? aluc : 4'b0000;
      o.pcsrc = wpc ? pcsrc : 2'b00;
      o.stall = stall_cnt;
      return o;
   endfunction

   task automatic drive(input logic r, input logic mr, input logic zz, input obs_t e, input string nm);
      clrn = r; mem_rdy = mr; z = zz;
      exp_q.push_back(e); nm_q.push_back(nm);
      @(negedge clk);
      obs_q.push_back(sample());
      if (r) sc = '0;
      else if ((e.st == S_IF || e.st == S_MEM) && !mr && sc != '1) sc = sc + 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      obs_t x, o; string nm;
      drive(1'b1, 1'b0, 1'b0, rst_rec(), "reset idle");
      drive(1'b1, 1'b1, 1'b0, rst_rec(), "reset rdy");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_rtype(input logic [5:0] f, input logic [3:0] ac, input logic sh);
      obs_t x, o, e; string nm;
      op = OP_RTYPE; func = f;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "rtype IF");
      drive(1'b0, 1'b0, 1'b0, rec(S_ID), "rtype ID");
      e = rec(S_EXE); e.aluc = ac; e.shift = sh;
      drive(1'b0, 1'b1, 1'b0, e, "rtype EXE");
      e = rec(S_WB); e.wreg = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "rtype WB");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_lw();
      obs_t x, o, e; string nm;
      op = OP_LW; func = 6'h15;
      drive(1'b0, 1'b0, 1'b0, fetch(1'b0), "lw IF wait");
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "lw IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "lw ID");
      e = rec(S_EXE); e.alusrcb = ASB_IMM; e.sext = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "lw EXE");
      for (int i = 0; i < 3; i++) begin
         e = rec(S_MEM); e.rmem = 1'b1;
         drive(1'b0, (i == 2), 1'b0, e, "lw MEM");
      end
      e = rec(S_WB); e.wreg = 1'b1; e.m2reg = 1'b1; e.regrt = 1'b1;
      drive(1'b0, 1'b0, 1'b0, e, "lw WB");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_sw();
      obs_t x, o, e; string nm;
      op = OP_SW; func = 6'h00;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "sw IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "sw ID");
      e = rec(S_EXE); e.alusrcb = ASB_IMM; e.sext = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "sw EXE");
      e = rec(S_MEM); e.wmem = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "sw MEM");
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "sw next IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "sw next ID");
      e = rec(S_EXE); e.alusrcb = ASB_IMM; e.sext = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "sw2 EXE");
      e = rec(S_MEM); e.wmem = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "sw2 MEM");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_branch(input logic [5:0] opc, input logic zz, input logic taken);
      obs_t x, o, e; string nm;
      op = opc; func = 6'h2a;
      drive(1'b0, 1'b1, zz, fetch(1'b1), "br IF");
      drive(1'b0, 1'b1, zz, rec(S_ID), "br ID");
      e = rec(S_EXE); e.aluc = ALUC_SUB; e.wpc = taken; e.pcsrc = taken ? PC_BPC : PC_P4;
      drive(1'b0, 1'b1, zz, e, "br EXE");
      drive(1'b0, 1'b0, zz, fetch(1'b0), "br back IF");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_jump();
      obs_t x, o, e; string nm;
      op = OP_JAL; func = 6'h3f;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "jal IF");
      e = rec(S_ID); e.wpc = 1'b1; e.pcsrc = PC_JPC; e.wreg = 1'b1; e.jal = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "jal ID");
      op = OP_J;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "j IF");
      e = rec(S_ID); e.wpc = 1'b1; e.pcsrc = PC_JPC;
      drive(1'b0, 1'b1, 1'b0, e, "j ID");
      op = OP_RTYPE; func = F_JR;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "jr IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "jr ID");
      e = rec(S_EXE); e.wpc = 1'b1; e.pcsrc = PC_QA;
      drive(1'b0, 1'b1, 1'b0, e, "jr EXE");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_itype(input logic [5:0] opc, input logic [3:0] ac, input logic sx);
      obs_t x, o, e; string nm;
      op = opc; func = 6'h21;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "itype IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "itype ID");
      e = rec(S_EXE); e.aluc = ac; e.alusrcb = ASB_IMM; e.sext = sx;
      drive(1'b0, 1'b1, 1'b0, e, "itype EXE");
      e = rec(S_WB); e.wreg = 1'b1; e.regrt = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "itype WB");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_illegal(input logic [5:0] opc, input logic [5:0] f);
      obs_t x, o, e; string nm;
      op = opc; func = f;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "ill IF");
      e = rec(S_ID); e.ill = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "ill ID");
      drive(1'b0, 1'b0, 1'b0, fetch(1'b0), "ill back IF");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_reset_mid_mem();
      obs_t x, o, e; string nm;
      op = OP_SW; func = 6'h00;
      drive(1'b0, 1'b1, 1'b0, fetch(1'b1), "rmm IF");
      drive(1'b0, 1'b1, 1'b0, rec(S_ID), "rmm ID");
      e = rec(S_EXE); e.alusrcb = ASB_IMM; e.sext = 1'b1;
      drive(1'b0, 1'b1, 1'b0, e, "rmm EXE");
      e = rec(S_MEM); e.wmem = 1'b1;
      drive(1'b0, 1'b0, 1'b0, e, "rmm MEM wait");
      e = rec(S_MEM);
      drive(1'b1, 1'b0, 1'b0, e, "rmm MEM clrn");
      drive(1'b1, 1'b0, 1'b0, rst_rec(), "rmm reset IF");
      drive(1'b0, 1'b0, 1'b0, fetch(1'b0), "rmm first fetch");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
   endtask

   task automatic test_saturate();
      obs_t x, o; string nm;
      for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 1'b0, fetch(1'b0), "sat IF");
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); checks++;
         if (o !== x) begin errors++; $display("FAIL %s: actual %h required %h", nm, o, x); end
      end
      checks++;
      if (stall_cnt !== {CW{1'b1}}) begin
         errors++; $display("FAIL sat final: actual %h required %h", stall_cnt, {CW{1'b1}});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      clrn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_rtype(F_ADD, ALUC_ADD, 1'b0);
      test_rtype(F_SRA, ALUC_SRA, 1'b1);
      test_rtype(F_XOR, ALUC_XOR, 1'b0);
      test_lw();
      test_sw();
      test_branch(OP_BEQ, 1'b1, 1'b1);
      test_branch(OP_BEQ, 1'b0, 1'b0);
      test_branch(OP_BNE, 1'b0, 1'b1);
      test_branch(OP_BNE, 1'b1, 1'b0);
      test_jump();
      test_itype(OP_ADDI, ALUC_ADD, 1'b1);
      test_itype(OP_LUI, ALUC_LUI, 1'b0);
      test_illegal(6'b111111, 6'b000000);
      test_illegal(OP_RTYPE, 6'b111111);
      test_reset_mid_mem();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
